// File: rtl/mko_host_resp.sv
// Responder end of the 1895VA2T MKO host strobe interface: register file with strobe/ready handshake and RT address latch.
// Optional RT address parity enforcement is enabled with `define MKO_RESP_PARITY_CHK_EN.
module mko_host_resp #(
  parameter int WB_DATA_WIDTH = 16,
  parameter int MKO_ADDR_W    = 4,
  parameter int WAIT_STATES   = 3
) (
  input  logic                     CLK_32,
  input  logic                     RESET,
  input  logic                     MKO_STRBD_N,
  input  logic                     MKO_SELECT_N,
  input  logic                     MKO_RDWR_N,
  input  logic [MKO_ADDR_W-1:0]    MKO_ADDR,
  input  logic [WB_DATA_WIDTH-1:0] MKO_DIN,
  output logic [WB_DATA_WIDTH-1:0] MKO_DOUT,
  output logic                     MKO_DOUT_OE,
  output logic                     MKO_READYD_N,
  input  logic                     MKO_RES_N,
  input  logic [4:0]               MKO_RDAT,
  input  logic                     MKO_RDATP,
  input  logic                     lcl_we,
  input  logic [MKO_ADDR_W-1:0]    lcl_addr,
  input  logic [WB_DATA_WIDTH-1:0] lcl_wdata,
  output logic [WB_DATA_WIDTH-1:0] lcl_rdata,
  output logic [4:0]               rt_addr,
  output logic                     rt_addr_err,
  output logic [15:0]              acc_cnt
);

  localparam int DEPTH = 2 ** MKO_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_READY,
    S_HOLD
  } state_t;

  // Synchronisers run on RESET only, so the MKO reset pin can itself drive the internal reset.
  logic r_strb_s1, r_strb_s2, r_strb_d;
  logic r_sel_s1, r_sel_s2;
  logic r_rdwr_s1, r_rdwr_s2;
  logic r_res_s1, r_res_s2, r_res_d;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK_32) begin
    if (RESET) begin
      r_strb_s1 <= 1'b1;
      r_strb_s2 <= 1'b1;
      r_strb_d  <= 1'b1;
      r_sel_s1  <= 1'b1;
      r_sel_s2  <= 1'b1;
      r_rdwr_s1 <= 1'b1;
      r_rdwr_s2 <= 1'b1;
      r_res_s1  <= 1'b0;
      r_res_s2  <= 1'b0;
      r_res_d   <= 1'b0;
    end else begin
      r_strb_s1 <= MKO_STRBD_N;
      r_strb_s2 <= r_strb_s1;
      r_strb_d  <= r_strb_s2;
      r_sel_s1  <= MKO_SELECT_N;
      r_sel_s2  <= r_sel_s1;
      r_rdwr_s1 <= MKO_RDWR_N;
      r_rdwr_s2 <= r_rdwr_s1;
      r_res_s1  <= MKO_RES_N;
      r_res_s2  <= r_res_s1;
      r_res_d   <= r_res_s2;
    end
  end

  logic w_rst;
  logic w_res_rise;
  logic w_access_en;

  assign w_rst      = RESET | ~r_res_s2;
  assign w_res_rise = r_res_s2 & ~r_res_d;

  logic [4:0] r_rt_addr;

  always_ff @(posedge CLK_32) begin
    if (w_rst) begin
      r_rt_addr <= '0;
    end else if (w_res_rise) begin
      r_rt_addr <= MKO_RDAT;
    end
  end

  assign rt_addr = r_rt_addr;

`ifdef MKO_RESP_PARITY_CHK_EN
  logic r_rt_err;

  // Odd parity over {RDATP, RDAT}: an even XOR marks the address word as corrupt.
  always_ff @(posedge CLK_32) begin
    if (w_rst) begin
      r_rt_err <= 1'b0;
    end else if (w_res_rise) begin
      r_rt_err <= ~^{MKO_RDATP, MKO_RDAT};
    end
  end

  assign rt_addr_err = r_rt_err;
  assign w_access_en = ~r_rt_err;
`else
  logic w_unused_rdatp;

  assign w_unused_rdatp = MKO_RDATP;
  assign rt_addr_err    = 1'b0;
  assign w_access_en    = 1'b1;
`endif

  state_t                   r_state;
  logic [3:0]               r_wait_cnt;
  logic [MKO_ADDR_W-1:0]    r_addr;
  logic [WB_DATA_WIDTH-1:0] r_din;
  logic                     r_rd;
  logic [WB_DATA_WIDTH-1:0] r_dout;
  logic                     r_dout_oe;
  logic                     r_readyd_n;
  logic [15:0]              r_acc_cnt;
  logic [WB_DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [WB_DATA_WIDTH-1:0] r_lcl_rdata;

  logic w_start;
  logic w_commit;
  logic w_bus_wr;

  assign w_start  = r_strb_d & ~r_strb_s2 & ~r_sel_s2 & w_access_en;
  assign w_commit = (r_state == S_WAIT) && (r_wait_cnt == 4'd0) && !r_strb_s2;
  assign w_bus_wr = w_commit & ~r_rd;

  always_ff @(posedge CLK_32) begin
    if (w_rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_din      <= '0;
      r_rd       <= 1'b1;
      r_dout     <= '0;
      r_dout_oe  <= 1'b0;
      r_readyd_n <= 1'b1;
      r_acc_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) r_state <= S_SETUP;
        end
        S_SETUP: begin
          if (r_strb_s2) begin
            r_state <= S_IDLE;
          end else begin
            r_addr     <= MKO_ADDR;
            r_din      <= MKO_DIN;
            r_rd       <= r_rdwr_s2;
            r_wait_cnt <= 4'(WAIT_STATES);
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_strb_s2) begin
            r_state <= S_IDLE;
          end else if (r_wait_cnt == 4'd0) begin
            r_state    <= S_READY;
            r_readyd_n <= 1'b0;
            if (r_rd) begin
              r_dout    <= r_mem[r_addr];
              r_dout_oe <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        S_READY: begin
          if (r_strb_s2) begin
            r_state   <= S_HOLD;
            r_acc_cnt <= r_acc_cnt + 16'd1;
          end
        end
        S_HOLD: begin
          r_readyd_n <= 1'b1;
          r_dout_oe  <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the register file is reset on purpose (it must read back zero after any reset), so it stays in flops.
  always_ff @(posedge CLK_32) begin
    if (w_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_lcl_rdata <= '0;
    end else begin
      if (w_bus_wr) begin
        r_mem[r_addr] <= r_din;
      end else if (lcl_we) begin
        r_mem[lcl_addr] <= lcl_wdata;
      end
      r_lcl_rdata <= r_mem[lcl_addr];
    end
  end

  assign MKO_DOUT     = r_dout;
  assign MKO_DOUT_OE  = r_dout_oe;
  assign MKO_READYD_N = r_readyd_n;
  assign lcl_rdata    = r_lcl_rdata;
  assign acc_cnt      = r_acc_cnt;

endmodule
